if_stage_fetch: RTL and testbench

//  Instruction-fetch stage of the pipelined (non-forwarding) RV32I core.
//  - Owns the PC register and the IF/ID pipeline register.
//  - Next PC is a 32-bit 2:1 selection: PC+4 or branch/jump target (i_pc_sel).
//  - Issues requests to instruction memory over a req/ack handshake.
//  - Honours stall from the hazard unit and redirect (flush) from EX.

---
 rtl/if_stage_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_if_stage_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// -----------------------------------------------------------------------------
// if_stage_fetch
//   Instruction-fetch stage of the pipelined (non-forwarding) RV32I core.
//   Owns the PC register and the IF/ID pipeline register, issues fetches over
//   a req/ack handshake, honours stall from the hazard unit and redirect
//   (flush) from EX.
//
// Parameters
//   RESET_PC   PC loaded at reset
//   NOP_INSTR  bubble instruction placed in IF/ID (addi x0,x0,0)
//
// Ports
//   i_clk, i_reset        clock; synchronous active-low reset
//   i_stall               hold PC and IF/ID
//   i_pc_sel, i_pc_target redirect to target and flush IF/ID
//   o_imem_req/o_imem_addr fetch request and address (addr stable until ack)
//   i_imem_ack/i_imem_rdata fetch completion and instruction data
//   o_pc_id, o_pc4_id, o_instr_id, o_valid_id   IF/ID register contents
//
// Optional build macro
//   IF_STAGE_PERF_CNT_EN  adds o_fetch_cnt (instructions accepted into IF/ID)
//                         and o_stall_cnt (cycles with i_stall=1).
// -----------------------------------------------------------------------------
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_pc_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_pc4_id,
    output logic [31:0] o_instr_id,
    output logic        o_valid_id
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        kill_reg, kill_next;         // outstanding fetch must be dropped
    logic [31:0] target_reg, target_next;     // redirect target saved while killing
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] pc_id_reg, pc_id_next;
    logic [31:0] pc4_id_reg, pc4_id_next;
    logic [31:0] instr_id_reg, instr_id_next;
    logic        valid_id_reg, valid_id_next;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32; low PC bits are carried through untouched.
    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        kill_next       = kill_reg;
        target_next     = target_reg;
        hold_instr_next = hold_instr_reg;
        pc_id_next      = pc_id_reg;
        pc4_id_next     = pc4_id_reg;
        instr_id_next   = instr_id_reg;
        valid_id_next   = valid_id_reg;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (i_imem_ack) begin
                    if (kill_reg) begin
                        // Fetch belonged to the squashed path: drop it.
                        kill_next = 1'b0;
                        pc_next   = target_reg;
                        if (!i_stall) begin
                            // A bubble uses the same contents as the reset value.
                            pc_id_next    = 32'd0;
                            pc4_id_next   = 32'd0;
                            instr_id_next = NOP_INSTR;
                            valid_id_next = 1'b0;
                        end
                    end else if (!i_stall) begin
                        pc_id_next    = pc_reg;
                        pc4_id_next   = pc_plus4;
                        instr_id_next = i_imem_rdata;
                        valid_id_next = 1'b1;
                        pc_next       = pc_plus4;
                    end else begin
                        // Data arrived while ID is frozen; park it until release.
                        hold_instr_next = i_imem_rdata;
                        state_next      = S_HOLD;
                    end
                end else if (!i_stall) begin
                    pc_id_next    = 32'd0;
                    pc4_id_next   = 32'd0;
                    instr_id_next = NOP_INSTR;
                    valid_id_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    pc_id_next    = pc_reg;
                    pc4_id_next   = pc_plus4;
                    instr_id_next = hold_instr_reg;
                    valid_id_next = 1'b1;
                    pc_next       = pc_plus4;
                    state_next    = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Redirect overrides everything above, including stall.
        if (i_pc_sel) begin
            pc_id_next    = 32'd0;
            pc4_id_next   = 32'd0;
            instr_id_next = NOP_INSTR;
            valid_id_next = 1'b0;
            state_next    = S_FETCH;
            if (state_reg == S_FETCH && !i_imem_ack) begin
                // Address must stay stable until the pending ack; remember
                // the target (a later redirect overwrites it) and kill the data.
                pc_next     = pc_reg;
                kill_next   = 1'b1;
                target_next = i_pc_target;
            end else begin
                pc_next   = i_pc_target;
                kill_next = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            kill_reg       <= 1'b0;
            target_reg     <= 32'd0;
            hold_instr_reg <= NOP_INSTR;
            pc_id_reg      <= 32'd0;
            pc4_id_reg     <= 32'd0;
            instr_id_reg   <= NOP_INSTR;
            valid_id_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            kill_reg       <= kill_next;
            target_reg     <= target_next;
            hold_instr_reg <= hold_instr_next;
            pc_id_reg      <= pc_id_next;
            pc4_id_reg     <= pc4_id_next;
            instr_id_reg   <= instr_id_next;
            valid_id_reg   <= valid_id_next;
        end
    end

    assign o_imem_req  = (state_reg == S_FETCH);
    assign o_imem_addr = pc_reg;
    assign o_pc_id     = pc_id_reg;
    assign o_pc4_id    = pc4_id_reg;
    assign o_instr_id  = instr_id_reg;
    assign o_valid_id  = valid_id_reg;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] stall_cnt_reg;
    logic        accept;

    // A real instruction enters IF/ID either straight from memory or from
    // the hold buffer; redirect turns both into a bubble.
    assign accept = !i_pc_sel && !i_stall &&
                    ((state_reg == S_FETCH && i_imem_ack && !kill_reg) ||
                     (state_reg == S_HOLD));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            fetch_cnt_reg <= 32'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            if (accept) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (i_stall) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = fetch_cnt_reg;
    assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Testbench for if_stage_fetch: directed vector table, wrap-around instance,
// reset-mid-request sequence, and a randomized run checked against a
// stream-level reference model of the fetch stage.
module tb_if_stage_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        pc_sel;
    logic [31:0] target;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc_id, pc4_id, instr_id;
    logic        valid_id;

    logic        w_req;
    logic [31:0] w_addr, w_pc, w_pc4, w_instr;
    logic        w_valid;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

    if_stage_fetch u_dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_stall      (stall),
        .i_pc_sel     (pc_sel),
        .i_pc_target  (target),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_ack   (ack),
        .i_imem_rdata (rdata),
        .o_pc_id      (pc_id),
        .o_pc4_id     (pc4_id),
        .o_instr_id   (instr_id),
        .o_valid_id   (valid_id)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .o_fetch_cnt  (fetch_cnt),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    // Wrap-around instance: zero-wait memory, never stalled.
    if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_stall      (1'b0),
        .i_pc_sel     (1'b0),
        .i_pc_target  (32'h0),
        .o_imem_req   (w_req),
        .o_imem_addr  (w_addr),
        .i_imem_ack   (1'b1),
        .i_imem_rdata (32'h1234_5678),
        .o_pc_id      (w_pc),
        .o_pc4_id     (w_pc4),
        .o_instr_id   (w_instr),
        .o_valid_id   (w_valid)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .o_fetch_cnt  (w_fetch_cnt),
        .o_stall_cnt  (w_stall_cnt)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C3C_5A5A;
    endfunction

    typedef struct {
        logic        stall;
        logic        sel;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[24];

    // Random-phase model state
    logic [31:0] m_exp_pc;
    int          m_fetch, m_stall;
    logic        c_stall, c_sel, c_ack, c_req;
    logic [31:0] c_tgt, c_addr, p_pc, p_pc4, p_instr;
    logic        p_valid;

    initial begin
        // stall sel tgt ack rdata | req addr | pc_id pc4_id instr valid (after edge)
        vecs[0]  = '{0, 0, 32'h0,   1, 32'hEEEE_0000, 0, 32'h0,   32'h0,   32'h0,   NOP,           0};
        vecs[1]  = '{0, 0, 32'h0,   1, 32'hA000_0000, 1, 32'h0,   32'h0,   32'h4,   32'hA000_0000, 1};
        vecs[2]  = '{0, 0, 32'h0,   1, 32'hA000_0004, 1, 32'h4,   32'h4,   32'h8,   32'hA000_0004, 1};
        vecs[3]  = '{1, 0, 32'h0,   1, 32'hA000_0008, 1, 32'h8,   32'h4,   32'h8,   32'hA000_0004, 1};
        vecs[4]  = '{1, 0, 32'h0,   0, 32'h0,         0, 32'h8,   32'h4,   32'h8,   32'hA000_0004, 1};
        vecs[5]  = '{1, 0, 32'h0,   1, 32'hDEAD_0005, 0, 32'h8,   32'h4,   32'h8,   32'hA000_0004, 1};
        vecs[6]  = '{0, 0, 32'h0,   0, 32'h0,         0, 32'h8,   32'h8,   32'hC,   32'hA000_0008, 1};
        vecs[7]  = '{0, 0, 32'h0,   0, 32'h0,         1, 32'hC,   32'h0,   32'h0,   NOP,           0};
        vecs[8]  = '{0, 0, 32'h0,   1, 32'hA000_000C, 1, 32'hC,   32'hC,   32'h10,  32'hA000_000C, 1};
        vecs[9]  = '{1, 0, 32'h0,   1, 32'hA000_0010, 1, 32'h10,  32'hC,   32'h10,  32'hA000_000C, 1};
        vecs[10] = '{1, 1, 32'h100, 0, 32'h0,         0, 32'h10,  32'h0,   32'h0,   NOP,           0};
        vecs[11] = '{0, 0, 32'h0,   1, 32'hC000_0100, 1, 32'h100, 32'h100, 32'h104, 32'hC000_0100, 1};
        vecs[12] = '{0, 1, 32'h200, 0, 32'h0,         1, 32'h104, 32'h0,   32'h0,   NOP,           0};
        vecs[13] = '{0, 0, 32'h0,   0, 32'h0,         1, 32'h104, 32'h0,   32'h0,   NOP,           0};
        vecs[14] = '{0, 0, 32'h0,   1, 32'hDEAD_0104, 1, 32'h104, 32'h0,   32'h0,   NOP,           0};
        vecs[15] = '{0, 0, 32'h0,   1, 32'hC000_0200, 1, 32'h200, 32'h200, 32'h204, 32'hC000_0200, 1};
        vecs[16] = '{0, 1, 32'h300, 0, 32'h0,         1, 32'h204, 32'h0,   32'h0,   NOP,           0};
        vecs[17] = '{0, 1, 32'h400, 0, 32'h0,         1, 32'h204, 32'h0,   32'h0,   NOP,           0};
        vecs[18] = '{0, 0, 32'h0,   1, 32'hDEAD_0204, 1, 32'h204, 32'h0,   32'h0,   NOP,           0};
        vecs[19] = '{0, 0, 32'h0,   1, 32'hC000_0400, 1, 32'h400, 32'h400, 32'h404, 32'hC000_0400, 1};
        vecs[20] = '{1, 0, 32'h0,   0, 32'h0,         1, 32'h404, 32'h400, 32'h404, 32'hC000_0400, 1};
        vecs[21] = '{0, 0, 32'h0,   1, 32'hC000_0404, 1, 32'h404, 32'h404, 32'h408, 32'hC000_0404, 1};
        vecs[22] = '{0, 1, 32'h500, 1, 32'hDEAD_0408, 1, 32'h408, 32'h0,   32'h0,   NOP,           0};
        vecs[23] = '{0, 0, 32'h0,   1, 32'hC000_0500, 1, 32'h500, 32'h500, 32'h504, 32'hC000_0500, 1};

        rst_n  = 1'b0;
        stall  = 1'b0;
        pc_sel = 1'b0;
        target = 32'h0;
        ack    = 1'b0;
        rdata  = 32'h0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(req),      32'h0);
        check("rst_pc",    pc_id,         32'h0);
        check("rst_pc4",   pc4_id,        32'h0);
        check("rst_instr", instr_id,      NOP);
        check("rst_valid", 32'(valid_id), 32'h0);
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            stall  = vecs[i].stall;
            pc_sel = vecs[i].sel;
            target = vecs[i].tgt;
            ack    = vecs[i].ack;
            rdata  = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_req", i),  32'(req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), addr,     vecs[i].exp_addr);
            if (i == 1) begin
                check("wrap_req1",  32'(w_req), 32'h1);
                check("wrap_addr1", w_addr,     32'hFFFF_FFFC);
            end
            if (i == 2) check("wrap_addr2", w_addr, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i),    pc_id,         vecs[i].exp_pc);
            check($sformatf("v%0d_pc4", i),   pc4_id,        vecs[i].exp_pc4);
            check($sformatf("v%0d_instr", i), instr_id,      vecs[i].exp_instr);
            check($sformatf("v%0d_valid", i), 32'(valid_id), 32'(vecs[i].exp_valid));
            if (i == 1) begin
                check("wrap_pc",    w_pc,           32'hFFFF_FFFC);
                check("wrap_pc4",   w_pc4,          32'h0);
                check("wrap_valid", 32'(w_valid),   32'h1);
            end
            $display("vec %0d: addr=%h id={%h,%h,%h,%0b}", i, addr, pc_id, pc4_id, instr_id, valid_id);
        end

        // ---------------- reset while a request waits for ack ----------------
        @(negedge clk);
        stall = 1'b0; pc_sel = 1'b0; ack = 1'b0;
        @(negedge clk);
        check("midrst_pre_req", 32'(req), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req",   32'(req),      32'h0);
        check("midrst_pc",    pc_id,         32'h0);
        check("midrst_pc4",   pc4_id,        32'h0);
        check("midrst_instr", instr_id,      NOP);
        check("midrst_valid", 32'(valid_id), 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("midrst_fcnt", fetch_cnt, 32'h0);
        check("midrst_scnt", stall_cnt, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF;   // late ack, must be ignored
        @(posedge clk);
        #1;
        check("midrst_late_valid", 32'(valid_id), 32'h0);
        check("midrst_next_req",   32'(req),      32'h1);
        check("midrst_next_addr",  addr,          32'h0);
        $display("midrst: req=%0b addr=%h valid=%0b", req, addr, valid_id);

`ifdef IF_STAGE_PERF_CNT_EN
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            stall = 1'b0; ack = 1'b1; rdata = 32'h1000 + 32'(k);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stall = 1'b1; ack = 1'b0;
        end
        @(negedge clk);
        stall = 1'b0;
        check("perf_fetch10", fetch_cnt, 32'd10);
        check("perf_stall4",  stall_cnt, 32'd4);
        $display("perf: fetch=%0d stall=%0d", fetch_cnt, stall_cnt);
`endif

        // ---------------- randomized run vs stream model ----------------
        @(negedge clk);
        stall = 1'b0; pc_sel = 1'b0; ack = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_exp_pc = 32'h0;
        m_fetch  = 0;
        m_stall  = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc != 0) @(negedge clk);
            c_stall = ($urandom_range(0, 3) == 0);
            c_sel   = ($urandom_range(0, 11) == 0);
            c_tgt   = $urandom & 32'h0003_FFFC;
            c_ack   = ($urandom_range(0, 1) == 1);
            stall   = c_stall;
            pc_sel  = c_sel;
            target  = c_tgt;
            ack     = c_ack;
            rdata   = memf(addr);
            #1;
            c_req   = req;
            c_addr  = addr;
            p_pc    = pc_id;
            p_pc4   = pc4_id;
            p_instr = instr_id;
            p_valid = valid_id;
            @(posedge clk);
            #1;
            if (c_req && !c_ack) begin
                check("rnd_req_hold",  32'(req), 32'h1);
                check("rnd_addr_hold", addr,     c_addr);
            end
            if (c_sel) begin
                check("rnd_redir_valid", 32'(valid_id), 32'h0);
                check("rnd_redir_instr", instr_id,      NOP);
                m_exp_pc = c_tgt;
            end else if (c_stall) begin
                check("rnd_stall_pc",    pc_id,         p_pc);
                check("rnd_stall_pc4",   pc4_id,        p_pc4);
                check("rnd_stall_instr", instr_id,      p_instr);
                check("rnd_stall_valid", 32'(valid_id), 32'(p_valid));
            end else if (valid_id) begin
                check("rnd_pc",    pc_id,    m_exp_pc);
                check("rnd_pc4",   pc4_id,   m_exp_pc + 32'd4);
                check("rnd_instr", instr_id, memf(m_exp_pc));
                m_exp_pc = m_exp_pc + 32'd4;
                m_fetch++;
                $display("rnd %0d: accepted pc=%h instr=%h", cyc, pc_id, instr_id);
            end else begin
                check("rnd_bubble_instr", instr_id, NOP);
            end
            if (c_stall) m_stall++;
`ifdef IF_STAGE_PERF_CNT_EN
            check("rnd_fcnt", fetch_cnt, 32'(m_fetch));
            check("rnd_scnt", stall_cnt, 32'(m_stall));
`endif
        end
        check("rnd_progress", 32'(m_fetch > 200), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
